// File: rtl/sse_pkg.sv
// Shared definitions for the sum-of-squared-error sequencer.
//   sse_state_t     : controller state encoding
//   FP_ZERO         : IEEE-754 single-precision +0.0
//   OP_ADD / OP_SUB : adder operation select values
//   DEFAULT_TIMEOUT : default watchdog limit in cycles
package sse_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StSubIssue,
    StSubWait,
    StMulIssue,
    StMulWait,
    StAccIssue,
    StAccWait,
    StDone,
    StDrain
  } sse_state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/sse_watchdog.sv
// Cycle counter guarding the controller's WAIT states.
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   i_clr    : restart the count (asserted in the cycle before a WAIT state)
//   i_en     : count this cycle (asserted while in a WAIT state)
//   o_expire : high on the TIMEOUT-th consecutive enabled cycle
module sse_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;

  // The count is 0 in the first WAIT cycle, so TIMEOUT-1 marks the last allowed cycle.
  assign o_expire = i_en && (r_cnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sse_accum_ctrl.sv
// Sequencer computing sum((x_i - y_i)^2) over a stream of single-precision pairs using a
// shared FP adder (subtract, then accumulate) and an external FP multiplier (square).
// One result is returned per vector, the vector being delimited by i_in_last.
//   i_clk, i_rst_n                   : clock, synchronous active-low reset
//   i_in_valid/o_in_ready            : sample pair handshake; i_in_x, i_in_y, i_in_last
//   o_out_valid/i_out_ready          : result handshake; o_out_sum, o_out_count, o_out_err
//   o_add_start/o_add_op/o_add_a/b   : adder request; i_add_ready, i_add_y result
//   o_mul_start/o_mul_a/o_mul_b      : multiplier request; i_mul_ready, i_mul_y result
//   o_busy                           : high in every state except idle
module sse_accum_ctrl
  import sse_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_x,
  input  logic [31:0]      i_in_y,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_sum,
  output logic [CNT_W-1:0] o_out_count,
  output logic             o_out_err,
  output logic             o_add_start,
  output logic             o_add_op,
  output logic [31:0]      o_add_a,
  output logic [31:0]      o_add_b,
  input  logic             i_add_ready,
  input  logic [31:0]      i_add_y,
  output logic             o_mul_start,
  output logic [31:0]      o_mul_a,
  output logic [31:0]      o_mul_b,
  input  logic             i_mul_ready,
  input  logic [31:0]      i_mul_y,
  output logic             o_busy
);

  sse_state_t       r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic [31:0]      r_acc;
  logic             r_acc_valid;

  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic [31:0]      r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_err;
  logic             r_add_start;
  logic             r_add_op;
  logic [31:0]      r_add_a;
  logic [31:0]      r_add_b;
  logic             r_mul_start;
  logic [31:0]      r_mul_a;
  logic [31:0]      r_mul_b;

  logic             w_in_fire;
  logic [CNT_W-1:0] w_count_inc;
  logic [31:0]      w_acc_hold;
  logic             w_wd_clr;
  logic             w_wd_en;
  logic             w_wd_expire;
  logic             w_unit_ready;
  logic             w_abort;
  logic             w_elem_end;
  logic [31:0]      w_acc_nx;
  logic             w_acc_valid_nx;

  assign w_in_fire   = i_in_valid && r_in_ready;
  assign w_count_inc = (&r_count) ? r_count : r_count + 1'b1;
  assign w_acc_hold  = r_acc_valid ? r_acc : FP_ZERO;

  assign w_wd_clr = (r_state == StSubIssue) || (r_state == StMulIssue) ||
                    (r_state == StAccIssue);
  assign w_wd_en  = (r_state == StSubWait) || (r_state == StMulWait) ||
                    (r_state == StAccWait);

  sse_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_wd_expire)
  );

  // Decode which unit result matters now and whether it completes the element. The first
  // nonzero square seeds the accumulator so the adder never sees a zero operand.
  always_comb begin
    w_unit_ready   = 1'b0;
    w_elem_end     = 1'b0;
    w_acc_nx       = r_acc;
    w_acc_valid_nx = r_acc_valid;
    case (r_state)
      StSubWait: begin
        w_unit_ready = i_add_ready;
        w_elem_end   = i_add_ready && (i_add_y[30:0] == 31'h0);
      end
      StMulWait: begin
        w_unit_ready = i_mul_ready;
        if (i_mul_ready && !r_acc_valid) begin
          w_elem_end     = 1'b1;
          w_acc_nx       = i_mul_y;
          w_acc_valid_nx = 1'b1;
        end
      end
      StAccWait: begin
        w_unit_ready = i_add_ready;
        if (i_add_ready) begin
          w_elem_end = 1'b1;
          w_acc_nx   = i_add_y;
        end
      end
      default: begin
      end
    endcase
  end

  // A unit result arriving on the expiry cycle still counts.
  assign w_abort = w_wd_expire && !w_unit_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_last      <= 1'b0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_acc       <= FP_ZERO;
      r_acc_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= FP_ZERO;
      r_out_count <= '0;
      r_out_err   <= 1'b0;
      r_add_start <= 1'b0;
      r_add_op    <= OP_ADD;
      r_add_a     <= FP_ZERO;
      r_add_b     <= FP_ZERO;
      r_mul_start <= 1'b0;
      r_mul_a     <= FP_ZERO;
      r_mul_b     <= FP_ZERO;
    end else begin
      r_add_start <= 1'b0;
      r_mul_start <= 1'b0;

      if (w_abort) begin
        r_err <= 1'b1;
        if (r_last) begin
          r_out_valid <= 1'b1;
          r_out_sum   <= w_acc_hold;
          r_out_count <= r_count;
          r_out_err   <= 1'b1;
          r_state     <= StDone;
        end else begin
          r_in_ready <= 1'b1;
          r_state    <= StDrain;
        end
      end else if (w_elem_end) begin
        r_acc       <= w_acc_nx;
        r_acc_valid <= w_acc_valid_nx;
        if (r_last) begin
          r_out_valid <= 1'b1;
          r_out_sum   <= w_acc_valid_nx ? w_acc_nx : FP_ZERO;
          r_out_count <= r_count;
          r_out_err   <= r_err;
          r_state     <= StDone;
        end else begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= StIdle;
        end
      end else begin
        unique case (r_state)
          StIdle: begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            if (w_in_fire) begin
              r_last      <= i_in_last;
              r_count     <= w_count_inc;
              r_add_start <= 1'b1;
              r_add_op    <= OP_SUB;
              r_add_a     <= i_in_x;
              r_add_b     <= i_in_y;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= StSubIssue;
            end
          end
          StSubIssue: r_state <= StSubWait;
          StSubWait: begin
            // Zero differences are already handled as an element end above.
            if (i_add_ready) begin
              r_mul_start <= 1'b1;
              r_mul_a     <= i_add_y;
              r_mul_b     <= i_add_y;
              r_state     <= StMulIssue;
            end
          end
          StMulIssue: r_state <= StMulWait;
          StMulWait: begin
            if (i_mul_ready) begin
              r_add_start <= 1'b1;
              r_add_op    <= OP_ADD;
              r_add_a     <= r_acc;
              r_add_b     <= i_mul_y;
              r_state     <= StAccIssue;
            end
          end
          StAccIssue: r_state <= StAccWait;
          StAccWait: begin
          end
          StDone: begin
            if (i_out_ready) begin
              r_acc       <= FP_ZERO;
              r_acc_valid <= 1'b0;
              r_count     <= '0;
              r_err       <= 1'b0;
              r_out_valid <= 1'b0;
              r_out_sum   <= FP_ZERO;
              r_out_count <= '0;
              r_out_err   <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= StIdle;
            end
          end
          StDrain: begin
            // Aborted vector: swallow pairs, still counting them, up to the last one.
            if (w_in_fire) begin
              r_count <= w_count_inc;
              if (i_in_last) begin
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
                r_out_sum   <= w_acc_hold;
                r_out_count <= w_count_inc;
                r_out_err   <= r_err;
                r_state     <= StDone;
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_busy      = r_busy;
  assign o_out_valid = r_out_valid;
  assign o_out_sum   = r_out_sum;
  assign o_out_count = r_out_count;
  assign o_out_err   = r_out_err;
  assign o_add_start = r_add_start;
  assign o_add_op    = r_add_op;
  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_mul_start = r_mul_start;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;

endmodule

// File: tb/tb_sse_accum_ctrl.sv
// Self-checking bench for sse_accum_ctrl with behavioural FP adder and multiplier.
module tb_sse_accum_ctrl;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [31:0]      in_y;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_err;
  logic             add_start;
  logic             add_op;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_ready = 1'b0;
  logic [31:0]      add_y = 32'h0;
  logic             mul_start;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic             mul_ready = 1'b0;
  logic [31:0]      mul_y = 32'h0;
  logic             busy;

  int tests = 0;
  int fails = 0;

  int lat_add = 2;
  int lat_mul = 3;
  bit mul_hang = 1'b0;
  int mul_starts = 0;

  always #5 clk = ~clk;

  sse_accum_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_x      (in_x),
    .i_in_y      (in_y),
    .i_in_last   (in_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_sum   (out_sum),
    .o_out_count (out_count),
    .o_out_err   (out_err),
    .o_add_start (add_start),
    .o_add_op    (add_op),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .i_add_ready (add_ready),
    .i_add_y     (add_y),
    .o_mul_start (mul_start),
    .o_mul_a     (mul_a),
    .o_mul_b     (mul_b),
    .i_mul_ready (mul_ready),
    .i_mul_y     (mul_y),
    .o_busy      (busy)
  );

  // Single <-> double conversion, valid for the normal, exactly representable values used here.
  function automatic real sp2real(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:0] == 31'h0) return 0.0;
    e = 11'(int'(s[30:23]) - 127 + 1023);
    return $bitstoreal({s[31], e, s[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] b;
    logic [7:0]  e;
    b = $realtobits(r);
    if (b[62:0] == 63'h0) return 32'h0;
    e = 8'(int'(b[62:52]) - 1023 + 127);
    return {b[63], e, b[51:29]};
  endfunction

  int          add_cnt = 0;
  bit          add_busy = 1'b0;
  logic [31:0] add_res = 32'h0;
  int          mul_cnt = 0;
  bit          mul_busy = 1'b0;
  logic [31:0] mul_res = 32'h0;

  // Behavioural adder: not reset, so a request in flight completes after a DUT reset.
  always @(posedge clk) begin
    add_ready <= 1'b0;
    if (add_start) begin
      add_busy <= 1'b1;
      add_cnt  <= lat_add;
      add_res  <= real2sp(add_op ? sp2real(add_a) - sp2real(add_b)
                                 : sp2real(add_a) + sp2real(add_b));
    end else if (add_busy) begin
      if (add_cnt <= 1) begin
        add_busy  <= 1'b0;
        add_ready <= 1'b1;
        add_y     <= add_res;
      end else begin
        add_cnt <= add_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    mul_ready <= 1'b0;
    if (mul_start) begin
      mul_starts <= mul_starts + 1;
      if (!mul_hang) begin
        mul_busy <= 1'b1;
        mul_cnt  <= lat_mul;
        mul_res  <= real2sp(sp2real(mul_a) * sp2real(mul_b));
      end
    end else if (mul_busy) begin
      if (mul_cnt <= 1) begin
        mul_busy  <= 1'b0;
        mul_ready <= 1'b1;
        mul_y     <= mul_res;
      end else begin
        mul_cnt <= mul_cnt - 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "global timeout");
  end

  // Reference: SSE over the vector in real arithmetic; all-zero differences give +0.
  function automatic logic [31:0] model_sse(input logic [31:0] xs[$], input logic [31:0] ys[$]);
    real acc = 0.0;
    real d;
    foreach (xs[i]) begin
      d = sp2real(xs[i]) - sp2real(ys[i]);
      acc = acc + d * d;
    end
    return real2sp(acc);
  endfunction

  task automatic send_pair(input logic [31:0] x, input logic [31:0] y, input logic last);
    int budget = 500;
    in_x = x;
    in_y = y;
    in_last = last;
    in_valid = 1'b1;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_pair: in_ready=%b, required 1 within 500 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic get_result(output logic [31:0] s, output logic [CNT_W-1:0] c,
                            output logic e, output logic ok);
    int budget = 2000;
    out_ready = 1'b1;
    while (!out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    s = out_sum;
    c = out_count;
    e = out_err;
    ok = out_valid;
    @(negedge clk);
  endtask

  task automatic run_vec(input logic [31:0] xs[$], input logic [31:0] ys[$],
                         output logic [31:0] s, output logic [CNT_W-1:0] c,
                         output logic e);
    logic ok;
    foreach (xs[i]) send_pair(xs[i], ys[i], i == xs.size() - 1);
    get_result(s, c, e, ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL result_timeout: out_valid=%b, required 1 within 2000 cycles", ok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_x = 32'h0;
    in_y = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_sum, out_count, out_err, add_start, add_op, add_a, add_b,
         mul_start, mul_a, mul_b, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b sum=%h cnt=%0d err=%b busy=%b, required all 0",
               in_ready, out_valid, out_sum, out_count, out_err, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 and 0", in_ready, busy);
    end
  endtask

  task automatic test_single_pair();
    logic [31:0] xs[$] = '{32'h4040_0000};
    logic [31:0] ys[$] = '{32'h3F80_0000};
    logic [31:0] s; logic [CNT_W-1:0] c; logic e;
    run_vec(xs, ys, s, c, e);
    tests++;
    if (s !== 32'h4080_0000 || c !== 16'd1 || e !== 1'b0) begin
      fails++;
      $display("FAIL single_pair: sum=%h cnt=%0d err=%b, required 40800000 1 0", s, c, e);
    end
  endtask

  task automatic test_two_elem();
    logic [31:0] xs[$] = '{32'h4040_0000, 32'h4000_0000};
    logic [31:0] ys[$] = '{32'h3F80_0000, 32'h3F00_0000};
    logic [31:0] s; logic [CNT_W-1:0] c; logic e;
    run_vec(xs, ys, s, c, e);
    tests++;
    if (s !== 32'h40C8_0000 || c !== 16'd2 || e !== 1'b0) begin
      fails++;
      $display("FAIL two_elem: sum=%h cnt=%0d err=%b, required 40c80000 2 0", s, c, e);
    end
  endtask

  task automatic test_zero_diff();
    logic [31:0] xs[$] = '{32'h3F80_0000};
    logic [31:0] ys[$] = '{32'h3F80_0000};
    logic [31:0] s; logic [CNT_W-1:0] c; logic e;
    int n0 = mul_starts;
    run_vec(xs, ys, s, c, e);
    tests++;
    if (mul_starts - n0 !== 0) begin
      fails++;
      $display("FAIL zero_diff_mul: mul_start pulses=%0d, required 0", mul_starts - n0);
    end
    tests++;
    if (s !== 32'h0 || c !== 16'd1 || e !== 1'b0) begin
      fails++;
      $display("FAIL zero_diff: sum=%h cnt=%0d err=%b, required 00000000 1 0", s, c, e);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] s; logic [CNT_W-1:0] c; logic e; logic ok;
    int budget = 200;
    int n = 0;
    mul_hang = 1'b1;
    send_pair(32'h4040_0000, 32'h3F80_0000, 1'b0);
    while (!mul_start && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != TIMEOUT + 1) begin
      fails++;
      $display("FAIL timeout_latency: cycles mul_start->in_ready=%0d, required %0d", n, TIMEOUT + 1);
    end
    send_pair(32'h4000_0000, 32'h3F00_0000, 1'b0);
    send_pair(32'h4000_0000, 32'h3F80_0000, 1'b1);
    get_result(s, c, e, ok);
    tests++;
    if (ok !== 1'b1 || s !== 32'h0 || c !== 16'd3 || e !== 1'b1) begin
      fails++;
      $display("FAIL timeout_result: valid=%b sum=%h cnt=%0d err=%b, required 1 00000000 3 1",
               ok, s, c, e);
    end
    mul_hang = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] xs[$] = '{32'h40A0_0000, 32'hC000_0000};
    logic [31:0] ys[$] = '{32'h3F80_0000, 32'h3F80_0000};
    logic [31:0] s0; logic [CNT_W-1:0] c0;
    logic [31:0] exp_s;
    int budget = 500;
    exp_s = model_sse(xs, ys);
    out_ready = 1'b0;
    send_pair(xs[0], ys[0], 1'b0);
    send_pair(xs[1], ys[1], 1'b1);
    while (!out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    s0 = out_sum;
    c0 = out_count;
    tests++;
    if (out_valid !== 1'b1 || s0 !== exp_s || c0 !== 16'd2) begin
      fails++;
      $display("FAIL bp_result: valid=%b sum=%h cnt=%0d, required 1 %h 2", out_valid, s0, c0, exp_s);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== s0 || out_count !== c0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b sum=%h cnt=%0d in_ready=%b, required 1 %h %0d 0",
                 i, out_valid, out_sum, out_count, in_ready, s0, c0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] xs[$] = '{32'h4040_0000, 32'h4000_0000};
    logic [31:0] ys[$] = '{32'h3F80_0000, 32'h3F00_0000};
    logic [31:0] s; logic [CNT_W-1:0] c; logic e;
    int budget = 500;
    bit seen = 1'b0;
    lat_add = 20;
    send_pair(xs[0], ys[0], 1'b0);
    send_pair(xs[1], ys[1], 1'b1);
    while (!(add_start && add_op == 1'b0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests++;
    if (add_start !== 1'b1 || add_op !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_acc_issue: add_start=%b add_op=%b, required 1 0", add_start, add_op);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_sum, out_count, out_err, add_start, add_op, add_a, add_b,
         mul_start, mul_a, mul_b, busy} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: busy=%b add_a=%h add_b=%h out_valid=%b, required all 0",
               busy, add_a, add_b, out_valid);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rst_mid_stale_ready: out_valid/busy went high=%b, required 0", seen);
    end
    lat_add = 2;
    run_vec(xs, ys, s, c, e);
    tests++;
    if (s !== 32'h40C8_0000 || c !== 16'd2 || e !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_next: sum=%h cnt=%0d err=%b, required 40c80000 2 0", s, c, e);
    end
  endtask

  task automatic test_random();
    for (int v = 0; v < 25; v++) begin
      logic [31:0] xs[$];
      logic [31:0] ys[$];
      logic [31:0] s; logic [CNT_W-1:0] c; logic e;
      logic [31:0] exp_s;
      int len = int'($urandom_range(5, 1));
      lat_add = int'($urandom_range(4, 1));
      lat_mul = int'($urandom_range(4, 1));
      for (int i = 0; i < len; i++) begin
        int kx = int'($urandom_range(32)) - 16;
        int ky = int'($urandom_range(32)) - 16;
        xs.push_back(real2sp(real'(kx) / 2.0));
        if ($urandom_range(3) == 0) ys.push_back(real2sp(real'(kx) / 2.0));
        else ys.push_back(real2sp(real'(ky) / 2.0));
      end
      exp_s = model_sse(xs, ys);
      run_vec(xs, ys, s, c, e);
      tests++;
      if (s !== exp_s || c !== CNT_W'(len) || e !== 1'b0) begin
        fails++;
        $display("FAIL random[%0d]: sum=%h cnt=%0d err=%b, required %h %0d 0", v, s, c, e,
                 exp_s, len);
      end
    end
    lat_add = 2;
    lat_mul = 3;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_two_elem();
    test_zero_diff();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
